// File: rtl/barrido_compuertas.sv
// Sweep stage for the two-input gate array: steps {entrada1,entrada2} through 00..11,
// captures the eight gate outputs per combination into a 32-bit table and checks it.
module barrido_compuertas #(
    parameter int unsigned ESPERA   = 4,
    parameter logic [31:0] ESPERADO = 32'hA3163ED8
) (
    input  logic        reloj,
    input  logic        reset,
    input  logic        inicio,
    output logic        entrada1,
    output logic        entrada2,
    input  logic [7:0]  obs,
    output logic        ocupado,
    output logic        listo,
    output logic        error,
    output logic [1:0]  indice_falla,
    output logic [31:0] tabla
);

    typedef enum logic [1:0] {REPOSO, APLICAR, FIN} estado_t;

    localparam logic [7:0] ULTIMO = 8'(ESPERA - 1);

    estado_t     estado_q, estado_d;
    logic [7:0]  contador_q, contador_d;
    logic [1:0]  k_q, k_d;
    logic [1:0]  entradas_q, entradas_d;
    logic [31:0] tabla_q, tabla_d;
    logic        falla_q, falla_d;
    logic [1:0]  idx_q, idx_d;
    logic        error_q, error_d;
    logic [1:0]  indice_q, indice_d;

    logic        captura;
    logic [7:0]  byte_esperado;

    assign captura       = (estado_q == APLICAR) && (contador_q == ULTIMO);
    assign byte_esperado = ESPERADO[{k_q, 3'b000} +: 8];

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        estado_d   = estado_q;
        contador_d = contador_q;
        k_d        = k_q;
        entradas_d = entradas_q;
        tabla_d    = tabla_q;
        falla_d    = falla_q;
        idx_d      = idx_q;
        error_d    = error_q;
        indice_d   = indice_q;

        case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    estado_d   = APLICAR;
                    contador_d = '0;
                    k_d        = '0;
                    entradas_d = 2'b00;
                    falla_d    = 1'b0;
                    idx_d      = '0;
                    error_d    = 1'b0;
                    indice_d   = '0;
                end
            end
            APLICAR: begin
                if (!captura) begin
                    contador_d = contador_q + 8'd1;
                end else begin
                    tabla_d[{k_q, 3'b000} +: 8] = obs;
                    // Only the first mismatching combination of the sweep is recorded.
                    if (obs != byte_esperado && !falla_q) begin
                        falla_d = 1'b1;
                        idx_d   = k_q;
                    end
                    if (k_q != 2'd3) begin
                        k_d        = k_q + 2'd1;
                        entradas_d = k_q + 2'd1;
                        contador_d = '0;
                    end else begin
                        estado_d = FIN;
                        error_d  = falla_d;
                        indice_d = idx_d;
                    end
                end
            end
            FIN:     estado_d = REPOSO;
            default: estado_d = REPOSO;
        endcase
    end

    // NOTE: reset is synchronous, so it only sits inside the clocked branch, not in the sensitivity list.
    always_ff @(posedge reloj) begin
        if (reset) begin
            estado_q   <= REPOSO;
            contador_q <= '0;
            k_q        <= '0;
            entradas_q <= 2'b00;
            tabla_q    <= '0;
            falla_q    <= 1'b0;
            idx_q      <= '0;
            error_q    <= 1'b0;
            indice_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all update together at the edge.
            estado_q   <= estado_d;
            contador_q <= contador_d;
            k_q        <= k_d;
            entradas_q <= entradas_d;
            tabla_q    <= tabla_d;
            falla_q    <= falla_d;
            idx_q      <= idx_d;
            error_q    <= error_d;
            indice_q   <= indice_d;
        end
    end

    assign entrada1     = entradas_q[1];
    assign entrada2     = entradas_q[0];
    assign ocupado      = (estado_q == APLICAR);
    assign listo        = (estado_q == FIN);
    assign error        = error_q;
    assign indice_falla = indice_q;
    assign tabla        = tabla_q;

endmodule

// File: tb/tb_barrido_compuertas.sv
// Bench for barrido_compuertas: a gate-block model with stuck-at fault masks feeds two
// instances (ESPERA=4 and ESPERA=1); results are checked against a truth-table model.
module tb_barrido_compuertas;

    localparam logic [31:0] GOLD = 32'hA3163ED8;

    logic reloj = 1'b0;
    always #5 reloj = ~reloj;

    logic       reset, inicio, sel;
    logic [7:0] f0, f1;

    logic        e1_4, e2_4, ocu_4, lis_4, err_4;
    logic [1:0]  idx_4;
    logic [31:0] tab_4;
    logic [7:0]  obs_4;
    logic        e1_1, e2_1, ocu_1, lis_1, err_1;
    logic [1:0]  idx_1;
    logic [31:0] tab_1;
    logic [7:0]  obs_1;
    logic        ini_4, ini_1;

    int errores = 0;
    int total   = 0;

    // Gate block: {xnor, nor, yes(b), nand, not(a), xor, or, and}.
    function automatic logic [7:0] compuertas(input logic a, input logic b);
        return {a ~^ b, ~(a | b), b, ~(a & b), ~a, a ^ b, a | b, a & b};
    endfunction

    assign obs_4 = (compuertas(e1_4, e2_4) & ~f0) | f1;
    assign obs_1 = (compuertas(e1_1, e2_1) & ~f0) | f1;
    assign ini_4 = inicio & ~sel;
    assign ini_1 = inicio & sel;

    barrido_compuertas #(.ESPERA(4), .ESPERADO(GOLD)) dut4 (
        .reloj(reloj), .reset(reset), .inicio(ini_4),
        .entrada1(e1_4), .entrada2(e2_4), .obs(obs_4),
        .ocupado(ocu_4), .listo(lis_4), .error(err_4),
        .indice_falla(idx_4), .tabla(tab_4)
    );

    barrido_compuertas #(.ESPERA(1), .ESPERADO(GOLD)) dut1 (
        .reloj(reloj), .reset(reset), .inicio(ini_1),
        .entrada1(e1_1), .entrada2(e2_1), .obs(obs_1),
        .ocupado(ocu_1), .listo(lis_1), .error(err_1),
        .indice_falla(idx_1), .tabla(tab_1)
    );

    logic [1:0]  s_ent, s_idx;
    logic        s_ocu, s_lis, s_err;
    logic [31:0] s_tab;
    assign s_ent = sel ? {e1_1, e2_1} : {e1_4, e2_4};
    assign s_ocu = sel ? ocu_1 : ocu_4;
    assign s_lis = sel ? lis_1 : lis_4;
    assign s_err = sel ? err_1 : err_4;
    assign s_idx = sel ? idx_1 : idx_4;
    assign s_tab = sel ? tab_1 : tab_4;

    typedef struct {
        logic [7:0]  f0;
        logic [7:0]  f1;
        logic [31:0] tabla;
        logic        err;
        logic [1:0]  idx;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
        total++;
        if (actual !== esperado) begin
            errores++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nombre, actual, esperado, $time);
        end
    endtask

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    // Expected table: each byte is the (faulted) gate response at combination k = {a,b}.
    function automatic logic [31:0] tabla_modelo(input logic [7:0] m0, input logic [7:0] m1);
        logic [31:0] t;
        logic [1:0]  k;
        t = '0;
        for (int i = 0; i < 4; i++) begin
            k = 2'(i);
            t[i*8 +: 8] = (compuertas(k[1], k[0]) & ~m0) | m1;
        end
        return t;
    endfunction

    function automatic logic [1:0] idx_modelo(input logic [31:0] t);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (t[i*8 +: 8] != GOLD[i*8 +: 8]) r = 2'(i);
        return r;
    endfunction

    task automatic chk_reposo(input string tag);
        check({tag, "_ent"}, 32'(s_ent), 32'd0);
        check({tag, "_ocu"}, 32'(s_ocu), 32'd0);
        check({tag, "_lis"}, 32'(s_lis), 32'd0);
        check({tag, "_err"}, 32'(s_err), 32'd0);
        check({tag, "_idx"}, 32'(s_idx), 32'd0);
        check({tag, "_tab"}, s_tab, 32'd0);
    endtask

    task automatic arrancar();
        inicio = 1'b1;
        tick();
    endtask

    // Called just after the acceptance edge E0; ends just after edge E0+4*esp+1.
    task automatic cuerpo(input int esp, input logic [31:0] et, input logic ee, input logic [1:0] ei);
        for (int j = 0; j < 4 * esp; j++) begin
            if (j == 0) begin
                check("err_clear", 32'(s_err), 32'd0);
                check("idx_clear", 32'(s_idx), 32'd0);
            end
            check("ocupado", 32'(s_ocu), 32'd1);
            check("listo_early", 32'(s_lis), 32'd0);
            check("entradas", 32'(s_ent), 32'(j / esp));
            tick();
        end
        check("listo", 32'(s_lis), 32'd1);
        check("ocupado_fin", 32'(s_ocu), 32'd0);
        check("tabla", s_tab, et);
        check("error", 32'(s_err), 32'(ee));
        check("indice", 32'(s_idx), 32'(ei));
        check("entradas_fin", 32'(s_ent), 32'd3);
        tick();
        check("listo_1cyc", 32'(s_lis), 32'd0);
        check("ocupado_rep", 32'(s_ocu), 32'd0);
        check("error_hold", 32'(s_err), 32'(ee));
        check("indice_hold", 32'(s_idx), 32'(ei));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] et;
        int          esp;
        logic        vio_listo;

        vecs[0] = '{f0: 8'h00, f1: 8'h00, tabla: 32'hA3163ED8, err: 1'b0, idx: 2'd0};
        vecs[1] = '{f0: 8'h01, f1: 8'h00, tabla: 32'hA2163ED8, err: 1'b1, idx: 2'd3};
        vecs[2] = '{f0: 8'h80, f1: 8'h08, tabla: 32'h2B1E3E58, err: 1'b1, idx: 2'd0};
        vecs[3] = '{f0: 8'h20, f1: 8'h00, tabla: 32'h83161ED8, err: 1'b1, idx: 2'd1};
        vecs[4] = '{f0: 8'hFF, f1: 8'h00, tabla: 32'h00000000, err: 1'b1, idx: 2'd0};

        sel = 1'b0; reset = 1'b1; inicio = 1'b0; f0 = '0; f1 = '0;
        tick();
        tick();
        chk_reposo("rst4");
        sel = 1'b1; #1;
        chk_reposo("rst1");
        sel = 1'b0;
        reset = 1'b0;
        tick();

        // Table-driven sweeps on the ESPERA=4 instance.
        foreach (vecs[i]) begin
            f0 = vecs[i].f0; f1 = vecs[i].f1;
            arrancar();
            inicio = 1'b0;
            cuerpo(4, vecs[i].tabla, vecs[i].err, vecs[i].idx);
        end

        // inicio held high: one sweep, then re-acceptance at E0+4*ESPERA+2.
        f0 = '0; f1 = '0;
        arrancar();
        cuerpo(4, GOLD, 1'b0, 2'd0);
        tick();
        check("hold_restart_ocu", 32'(s_ocu), 32'd1);
        check("hold_restart_ent", 32'(s_ent), 32'd0);
        inicio = 1'b0;
        cuerpo(4, GOLD, 1'b0, 2'd0);

        // Reset during combination 2 after a failing sweep.
        f0 = vecs[1].f0; f1 = vecs[1].f1;
        arrancar();
        inicio = 1'b0;
        cuerpo(4, vecs[1].tabla, 1'b1, 2'd3);
        f0 = '0; f1 = '0;
        arrancar();
        inicio = 1'b0;
        for (int j = 0; j < 9; j++) tick();
        check("pre_rst_ent", 32'(s_ent), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reposo("midrst");
        vio_listo = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (s_lis || s_ocu) vio_listo = 1'b1;
        end
        check("no_listo_after_rst", 32'(vio_listo), 32'd0);
        arrancar();
        inicio = 1'b0;
        cuerpo(4, GOLD, 1'b0, 2'd0);

        // ESPERA=1: fault-free, failing, then fault-free again.
        sel = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            f0 = (i == 1) ? vecs[1].f0 : 8'h00;
            f1 = 8'h00;
            arrancar();
            inicio = 1'b0;
            cuerpo(1, (i == 1) ? vecs[1].tabla : GOLD, i == 1, (i == 1) ? 2'd3 : 2'd0);
        end

        // Random stuck-at faults on either instance against the truth-table model.
        for (int i = 0; i < 12; i++) begin
            sel = 1'($urandom_range(0, 1));
            f0  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            f1  = 8'($urandom) & 8'($urandom) & 8'($urandom) & ~f0;
            if ($urandom_range(0, 3) == 0) begin
                f0 = '0; f1 = '0;
            end
            esp = sel ? 1 : 4;
            et  = tabla_modelo(f0, f1);
            tick();
            arrancar();
            inicio = 1'b0;
            cuerpo(esp, et, et != GOLD, idx_modelo(et));
        end

        $display("Result: errors=%0d of %0d checks", errores, total);
        $finish;
    end

endmodule
